// File: rtl/axi_wr_native_bridge.sv
// AXI write burst -> native single-beat command + data adapter; optional w_last check under AXI_WR_LAST_CHECK_EN.
// Latency: AW to first native cmd 1 cycle; 2 cycles minimum per beat (CMD then DATA); B one cycle after final beat.
// Backpressure: cmd/B valids are registered and held until accepted; W<->wdata is a combinational valid/ready pass-through.
module axi_wr_native_bridge #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 256,
   parameter int ID_W   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   // AXI AW channel
   input  logic                  axi_aw_valid,
   output logic                  axi_aw_ready,
   input  logic [ADDR_W-1:0]     axi_aw_payload_addr,
   input  logic [1:0]            axi_aw_payload_burst,
   input  logic [7:0]            axi_aw_payload_len,
   input  logic [3:0]            axi_aw_payload_size,
   input  logic [ID_W-1:0]       axi_aw_payload_id,
   // AXI W channel
   input  logic                  axi_w_valid,
   output logic                  axi_w_ready,
   input  logic                  axi_w_last,
   input  logic [DATA_W-1:0]     axi_w_payload_data,
   input  logic [DATA_W/8-1:0]   axi_w_payload_strb,
   // AXI B channel
   output logic                  axi_b_valid,
   input  logic                  axi_b_ready,
   output logic [1:0]            axi_b_payload_resp,
   output logic [ID_W-1:0]       axi_b_payload_id,
   // native command stream
   output logic                  native_cmd_valid,
   input  logic                  native_cmd_ready,
   output logic                  native_cmd_first,
   output logic                  native_cmd_last,
   output logic                  native_cmd_payload_we,
   output logic                  native_cmd_payload_mw,
   output logic [ADDR_W-1:0]     native_cmd_payload_addr,
   // native write data stream
   output logic                  wdata_valid,
   input  logic                  wdata_ready,
   output logic                  wdata_first,
   output logic                  wdata_last,
   output logic [DATA_W-1:0]     wdata_payload_data,
   output logic [DATA_W/8-1:0]   wdata_payload_we
);

   // Word address width: a beat is 32 bytes, so the low 5 byte-address bits drop out.
   localparam int WA_W = ADDR_W - 5;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CMD,
      S_DATA,
      S_RESP
   } state_t;

   state_t            state;
   logic              aw_rdy_q;
   logic              cmd_vld_q;
   logic              data_q;
   logic              b_vld_q;
   logic [ID_W-1:0]   id_q;
   logic [7:0]        len_q;
   logic [1:0]        burst_q;
   logic [WA_W-1:0]   waddr_q;
   logic [7:0]        beat_q;
   logic              err_q;
   logic [1:0]        resp_q;

   logic              w_hs;
   logic              beat_is_last;
   logic              last_err;
   logic              err_next;

   // Next word address for the burst type. WRAP only wraps for the
   // power-of-two lengths 2/4/8/16 beats; any other length degrades to INCR.
   function automatic logic [WA_W-1:0] next_addr(input logic [WA_W-1:0] a,
                                                 input logic [1:0]      burst,
                                                 input logic [7:0]      len);
      logic [WA_W-1:0] inc;
      logic [WA_W-1:0] mask;
      logic            wrap_ok;
      logic [WA_W-1:0] res;
      inc     = a + WA_W'(1);
      mask    = '0;
      wrap_ok = 1'b1;
      case (len)
         8'd1:    mask = WA_W'(4'h1);
         8'd3:    mask = WA_W'(4'h3);
         8'd7:    mask = WA_W'(4'h7);
         8'd15:   mask = WA_W'(4'hF);
         default: wrap_ok = 1'b0;
      endcase
      if (burst == BURST_FIXED) begin
         res = a;
      end else if ((burst == BURST_WRAP) && wrap_ok) begin
         res = (a & ~mask) | (inc & mask);
      end else begin
         res = inc;
      end
      return res;
   endfunction

   assign w_hs         = data_q & axi_w_valid & wdata_ready;
   assign beat_is_last = (beat_q == len_q);

`ifdef AXI_WR_LAST_CHECK_EN
   // A w_last that disagrees with the beat count flags the burst; the count still rules termination.
   assign last_err = w_hs & (axi_w_last != beat_is_last);
   logic unused_bits;
   assign unused_bits = ^axi_aw_payload_addr[4:0];
`else
   // w_last carries no information here: the burst length comes from AW.
   assign last_err = 1'b0;
   logic unused_bits;
   assign unused_bits = ^{axi_aw_payload_addr[4:0], axi_w_last};
`endif

   assign err_next = err_q | last_err;

   // Burst sequencer: owns every registered handshake output.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         aw_rdy_q  <= 1'b0;
         cmd_vld_q <= 1'b0;
         data_q    <= 1'b0;
         b_vld_q   <= 1'b0;
         id_q      <= '0;
         len_q     <= '0;
         burst_q   <= '0;
         waddr_q   <= '0;
         beat_q    <= '0;
         err_q     <= 1'b0;
         resp_q    <= RESP_OKAY;
      end else begin
         case (state)
            S_IDLE: begin
               if (aw_rdy_q && axi_aw_valid) begin
                  id_q      <= axi_aw_payload_id;
                  len_q     <= axi_aw_payload_len;
                  burst_q   <= axi_aw_payload_burst;
                  waddr_q   <= axi_aw_payload_addr[ADDR_W-1:5];
                  beat_q    <= '0;
                  err_q     <= (axi_aw_payload_size != 4'd5);
                  aw_rdy_q  <= 1'b0;
                  cmd_vld_q <= 1'b1;
                  state     <= S_CMD;
               end else begin
                  aw_rdy_q  <= 1'b1;
               end
            end
            S_CMD: begin
               if (native_cmd_ready) begin
                  cmd_vld_q <= 1'b0;
                  data_q    <= 1'b1;
                  state     <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_hs) begin
                  err_q  <= err_next;
                  data_q <= 1'b0;
                  if (beat_is_last) begin
                     b_vld_q <= 1'b1;
                     resp_q  <= err_next ? RESP_SLVERR : RESP_OKAY;
                     state   <= S_RESP;
                  end else begin
                     beat_q    <= beat_q + 8'd1;
                     waddr_q   <= next_addr(waddr_q, burst_q, len_q);
                     cmd_vld_q <= 1'b1;
                     state     <= S_CMD;
                  end
               end
            end
            S_RESP: begin
               if (axi_b_ready) begin
                  b_vld_q  <= 1'b0;
                  aw_rdy_q <= 1'b1;
                  state    <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign axi_aw_ready            = aw_rdy_q;

   assign native_cmd_valid        = cmd_vld_q;
   assign native_cmd_first        = 1'b1;
   assign native_cmd_last         = 1'b1;
   assign native_cmd_payload_we   = 1'b1;
   assign native_cmd_payload_mw   = 1'b0;
   assign native_cmd_payload_addr = {{5{1'b0}}, waddr_q};

   assign wdata_valid             = data_q & axi_w_valid;
   assign axi_w_ready             = data_q & wdata_ready;
   assign wdata_first             = data_q & (beat_q == 8'd0);
   assign wdata_last              = data_q & beat_is_last;
   assign wdata_payload_data      = axi_w_payload_data;
   assign wdata_payload_we        = axi_w_payload_strb;

   assign axi_b_valid             = b_vld_q;
   assign axi_b_payload_resp      = resp_q;
   assign axi_b_payload_id        = id_q;

endmodule
